// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the 12-by-6 bit sequential divider.
// The master side requests divisions; the slave side (the divider) returns results.
interface seq_divider_if;
  logic        start;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned 12/6 restoring divider: one quotient bit per clock, 12 steps per division.
// A zero divisor bypasses the iteration and reports an all-ones quotient.
module seq_divider (
  input  logic       clk,
  input  logic       rst,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  state_t      state_next;

  logic [11:0] dq;
  logic [6:0]  pr;
  logic [5:0]  dv;
  logic [3:0]  cnt;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        div_by_zero;

  logic        accept;
  logic        last_step;
  logic [6:0]  shifted;
  logic [6:0]  trial;
  logic        fits;
  logic [11:0] dq_next;
  logic [6:0]  pr_next;

  assign accept    = bus.start && (state != CALC);
  assign last_step = (state == CALC) && (cnt == 4'd0);

  assign shifted = {pr[5:0], dq[11]};
  assign trial   = shifted - {1'b0, dv};
  // pr[6] is never set by a legal step; folding it in keeps the full register observable.
  assign fits    = ~trial[6] | pr[6];
  assign dq_next = {dq[10:0], fits};
  assign pr_next = fits ? trial : shifted;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_next = (bus.divisor == 6'd0) ? DONE : CALC;
        else        state_next = IDLE;
      end
      CALC:    if (cnt == 4'd0) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      CALC:    bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dq          <= '0;
      pr          <= '0;
      dv          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dq  <= bus.dividend;
      pr  <= '0;
      dv  <= bus.divisor;
      cnt <= 4'd11;
      if (bus.divisor == 6'd0) begin
        quotient    <= 12'hFFF;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == CALC) begin
      dq  <= dq_next;
      pr  <= pr_next;
      cnt <= cnt - 4'd1;
      if (last_step) begin
        quotient  <= dq_next;
        remainder <= pr_next[5:0];
      end
    end
  end

  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: hand-computed quotients, latency, zero divisor,
// ignored start, back-to-back accept and reset abort.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst;

  seq_divider_if bus ();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Presents operands for one edge, then scrambles them to prove they were captured.
  task automatic start_op(input logic [11:0] a, input logic [5:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 12'($urandom);
    bus.divisor  = 6'($urandom);
  endtask

  // Counts edges from the accept edge until done; optionally pulses a stray start at poke_at.
  task automatic wait_done(input int poke_at, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (lat == poke_at) begin
        bus.start    = 1'b1;
        bus.dividend = 12'd50;
        bus.divisor  = 6'd5;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [11:0] a, input logic [5:0] b,
                     input logic [11:0] eq, input logic [5:0] er, input logic ez,
                     input int elat, input int poke_at);
    int lat;
    int bc;
    start_op(a, b);
    wait_done(poke_at, lat, bc);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, bc, elat);
    check({tag, "_busy_at_done"}, bus.busy, 1'b0);
    check({tag, "_quotient"}, bus.quotient, eq);
    check({tag, "_remainder"}, bus.remainder, er);
    check({tag, "_div_by_zero"}, bus.div_by_zero, ez);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 1'b0);
    check({tag, "_quotient_hold"}, bus.quotient, eq);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;

    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("reset_quotient", bus.quotient, 0);
    check("reset_remainder", bus.remainder, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_div_by_zero", bus.div_by_zero, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    run("basic",        12'd100,  6'd7,  12'd14,   6'd2, 1'b0, 12, -1);
    run("max_by_one",   12'd4095, 6'd1,  12'd4095, 6'd0, 1'b0, 12, -1);
    run("small_by_max", 12'd5,    6'd63, 12'd0,    6'd5, 1'b0, 12, -1);
    run("max_by_max",   12'd4095, 6'd63, 12'd65,   6'd0, 1'b0, 12, -1);
    run("div_zero",     12'd37,   6'd0,  12'hFFF,  6'd0, 1'b1, 0,  -1);
    run("after_zero",   12'd1000, 6'd3,  12'd333,  6'd1, 1'b0, 12, -1);
    run("ignored_start",12'd200,  6'd9,  12'd22,   6'd2, 1'b0, 12, 6);

    // Back-to-back: start held through the done cycle of 100/7.
    start_op(12'd100, 6'd7);
    wait_done(-1, lat, bc);
    check("b2b_first_latency", lat, 12);
    check("b2b_first_quotient", bus.quotient, 14);
    bus.start    = 1'b1;
    bus.dividend = 12'd77;
    bus.divisor  = 6'd11;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_accept_busy", bus.busy, 1);
    check("b2b_accept_done", bus.done, 0);
    check("b2b_accept_clear", bus.quotient, 0);
    wait_done(-1, lat, bc);
    check("b2b_second_latency", lat + 1, 13);
    check("b2b_second_quotient", bus.quotient, 7);
    check("b2b_second_remainder", bus.remainder, 0);
    @(posedge clk); #1;

    // Reset abort at step 5 of 300/13.
    start_op(12'd300, 6'd13);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("abort_busy_before", bus.busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_div_by_zero", bus.div_by_zero, 0);
    @(posedge clk); #1;
    rst  = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
    end
    check("abort_no_done", seen, 0);
    run("after_reset", 12'd300, 6'd13, 12'd23, 6'd1, 1'b0, 12, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
